// File: rtl/vline_pkg.sv
// vline_pkg: definitions shared by the vertical-line controller and the
// position counter it drives.
//   - FSM state encoding of vline_move_ctrl
//   - Y limits where the position counter raises at_top / at_bot
package vline_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam logic [15:0] Y_TOP = 16'd487;
   localparam logic [15:0] Y_BOT = 16'd18;

endpackage

// File: rtl/vline_move_ctrl_frame_divider.sv
// frame_divider: counts frame ticks and flags the tick that completes a
// group of TERM frames. The horizontal-line controller reuses it.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : synchronous clear of the count (wins over tick)
//   tick       : one-cycle frame pulse
//   tc         : high with the tick that completes the group; the count
//                wraps to zero on that tick
module frame_divider #(
   parameter int TERM = 2,
   parameter int W    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic tick,
   output logic tc
);

   localparam logic [W-1:0] LAST = W'(TERM - 1);

   logic [W-1:0] cnt;

   assign tc = tick & (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vline_move_ctrl.sv
// vline_move_ctrl: initiator for the vertical-line position counter.
// Steps the counter once every STEP_FRAMES frames, bounces between the
// top and bottom limits, loads the switch value on request and counts
// bounces (saturating) for the score logic.
//   clk, reset        : pixel clock, asynchronous active-low reset
//   frame_tick        : one pulse per frame
//   start, stop       : enter / leave motion
//   load_req          : request a load of the switch value
//   at_top, at_bot    : counter limit flags, sampled only at step events
//   UP, DW, LD        : registered one-cycle strobes to the counter
//   dir               : 1 = incrementing, 0 = decrementing
//   running           : high while moving
//   bounces           : saturating count of direction reversals
module vline_move_ctrl
   import vline_pkg::*;
#(
   parameter int STEP_FRAMES = 2,
   parameter int DIV_W       = 4,
   parameter int BOUNCE_W    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frame_tick,
   input  logic                start,
   input  logic                stop,
   input  logic                load_req,
   input  logic                at_top,
   input  logic                at_bot,
   output logic                UP,
   output logic                DW,
   output logic                LD,
   output logic                dir,
   output logic                running,
   output logic [BOUNCE_W-1:0] bounces
);

   logic [1:0] state;
   logic       div_clr;
   logic       step;

   function automatic logic [BOUNCE_W-1:0] sat_inc(input logic [BOUNCE_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // The divider only runs undisturbed in RUN; any exit from RUN (load or
   // stop) and all non-RUN cycles hold it at zero, so every entry into RUN
   // starts a fresh frame group.
   assign div_clr = (state != ST_RUN) | load_req | stop;

   frame_divider #(
      .TERM (STEP_FRAMES),
      .W    (DIV_W)
   ) u_div (
      .clk   (clk),
      .reset (reset),
      .clr   (div_clr),
      .tick  (frame_tick),
      .tc    (step)
   );

   // LOAD actions (LD strobe, dir forced to 1) are registered on entry so
   // they are visible during the single LOAD cycle itself.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         UP      <= 1'b0;
         DW      <= 1'b0;
         LD      <= 1'b0;
         dir     <= 1'b1;
         running <= 1'b0;
         bounces <= '0;
      end else begin
         UP <= 1'b0;
         DW <= 1'b0;
         LD <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load_req) begin
                  state <= ST_LOAD;
                  LD    <= 1'b1;
                  dir   <= 1'b1;
               end else if (start) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_LOAD: begin
               state <= ST_IDLE;
               dir   <= 1'b1;
            end
            ST_RUN: begin
               if (load_req) begin
                  state   <= ST_LOAD;
                  running <= 1'b0;
                  LD      <= 1'b1;
                  dir     <= 1'b1;
               end else if (stop) begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
               end else if (step) begin
                  // Both flags at once cannot happen on a real counter;
                  // stand still rather than guess a direction.
                  if (at_top && at_bot) begin
                     dir <= dir;
                  end else if (dir && at_top) begin
                     dir     <= 1'b0;
                     DW      <= 1'b1;
                     bounces <= sat_inc(bounces);
                  end else if (!dir && at_bot) begin
                     dir     <= 1'b1;
                     UP      <= 1'b1;
                     bounces <= sat_inc(bounces);
                  end else begin
                     UP <= dir;
                     DW <= ~dir;
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vline_move_ctrl.sv
// Scoreboard bench for vline_move_ctrl: the driver applies inputs on the
// falling edge and pushes the outputs the behavioural model predicts for
// the following rising edge; the monitor pops and compares after each
// rising edge.
module tb_vline_move_ctrl;

   localparam int STEP = 2;

   typedef struct packed {
      logic       up;
      logic       dw;
      logic       ld;
      logic       dir;
      logic       running;
      logic [7:0] bounces;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0, start = 1'b0, stop = 1'b0, load_req = 1'b0;
   logic       at_top = 1'b0, at_bot = 1'b0;
   logic       UP, DW, LD, dir, running;
   logic [7:0] bounces;

   vline_move_ctrl #(.STEP_FRAMES(STEP), .DIV_W(4), .BOUNCE_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .start      (start),
      .stop       (stop),
      .load_req   (load_req),
      .at_top     (at_top),
      .at_bot     (at_bot),
      .UP         (UP),
      .DW         (DW),
      .LD         (LD),
      .dir        (dir),
      .running    (running),
      .bounces    (bounces)
   );

   always #20 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   exp_t sbq[$];

   // Behavioural model: mode 0 = idle, 1 = loading, 2 = moving.
   int m_mode = 0;
   int m_frames = 0;
   bit m_dir = 1'b1;
   int m_bounce = 0;

   task automatic check_vec(input string name, input exp_t act, input exp_t req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s t=%0t got UP=%b DW=%b LD=%b dir=%b run=%b bnc=%0d required UP=%b DW=%b LD=%b dir=%b run=%b bnc=%0d",
                    name, $time, act.up, act.dw, act.ld, act.dir, act.running, act.bounces,
                    req.up, req.dw, req.ld, req.dir, req.running, req.bounces);
   endtask

   task automatic check_int(input string name, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s got %0d required %0d", name, act, req);
   endtask

   function automatic exp_t dut_vec();
      exp_t a;
      a = {UP, DW, LD, dir, running, bounces};
      return a;
   endfunction

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_vec("outputs", dut_vec(), e);
         end
      end
   end

   task automatic do_step(inout exp_t e, input bit t, input bit b);
      if (t && b) begin
         // illegal flag combination: nothing happens
      end else if (m_dir && t) begin
         m_dir = 1'b0; e.dw = 1'b1; m_bounce = (m_bounce < 255) ? m_bounce + 1 : 255;
      end else if (!m_dir && b) begin
         m_dir = 1'b1; e.up = 1'b1; m_bounce = (m_bounce < 255) ? m_bounce + 1 : 255;
      end else if (m_dir) e.up = 1'b1;
      else e.dw = 1'b1;
   endtask

   // Driver: one clock of stimulus plus the model's prediction for it.
   task automatic cyc(input bit ft, input bit st, input bit sp, input bit lr,
                      input bit t, input bit b, output exp_t e);
      @(negedge clk);
      frame_tick = ft; start = st; stop = sp; load_req = lr; at_top = t; at_bot = b;
      e = '0;
      case (m_mode)
         0: begin
            if (lr) begin m_mode = 1; e.ld = 1'b1; m_dir = 1'b1; end
            else if (st) begin m_mode = 2; m_frames = 0; end
         end
         1: m_mode = 0;
         default: begin
            if (lr) begin m_mode = 1; e.ld = 1'b1; m_dir = 1'b1; m_frames = 0; end
            else if (sp) begin m_mode = 0; m_frames = 0; end
            else if (ft) begin
               m_frames++;
               if (m_frames == STEP) begin
                  m_frames = 0;
                  do_step(e, t, b);
               end
            end
         end
      endcase
      e.dir = m_dir;
      e.running = (m_mode == 2);
      e.bounces = 8'(m_bounce);
      sbq.push_back(e);
   endtask

   task automatic c(input bit ft, input bit st, input bit sp, input bit lr,
                    input bit t, input bit b);
      exp_t e;
      cyc(ft, st, sp, lr, t, b, e);
   endtask

   initial begin
      exp_t e, rv;
      bit found;
      rv = '0; rv.dir = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #5;
      check_vec("reset_state", dut_vec(), rv);
      @(negedge clk);
      reset = 1'b1;

      // Plain stepping: 6 ticks -> 3 UP pulses
      c(0,1,0,0,0,0);
      for (int i = 0; i < 6; i++) begin
         c(1,0,0,0,0,0); c(0,0,0,0,0,0); c(0,0,0,0,0,0);
      end

      // Bounce at top, step down, bounce at bottom
      c(1,0,0,0,0,0); c(1,0,0,0,1,0);
      c(1,0,0,0,0,0); c(0,0,0,0,0,0); c(1,0,0,0,0,0);
      c(1,0,0,0,0,0); c(1,0,0,0,0,1); c(0,0,0,0,0,0);

      // Load coincident with a stepping tick, then ticks while idle
      c(1,0,0,0,0,0); c(1,0,0,1,0,0);
      for (int i = 0; i < 6; i++) c(1,0,0,0,0,0);

      // Start and stop together in RUN
      c(0,1,0,0,0,0); c(1,1,1,0,0,0); c(1,0,0,0,0,0); c(1,0,0,0,0,0);

      // Illegal flags at a step tick
      c(0,1,0,0,0,0); c(1,0,0,0,0,0); c(1,0,0,0,1,1); c(1,0,0,0,0,0); c(1,0,0,0,1,1);
      c(0,0,1,0,0,0);

      // Mixed random traffic
      for (int i = 0; i < 800; i++)
         c($urandom_range(0,2) == 0, $urandom_range(0,9) == 0, $urandom_range(0,29) == 0,
           $urandom_range(0,49) == 0, $urandom_range(0,4) == 0, $urandom_range(0,4) == 0);

      // Drive towards saturation: flags follow the direction of travel
      c(0,1,0,0,0,0);
      for (int i = 0; i < 1400; i++)
         c($urandom_range(0,2) != 0, 0, 0, 0, m_dir, !m_dir);
      @(negedge clk);
      check_int("bounce_saturated", int'(bounces), 255);
      for (int i = 0; i < 20; i++) c(1, 0, 0, 0, m_dir, !m_dir);

      // Asynchronous reset while DW is high
      found = 1'b0;
      c(0,1,0,0,0,0);
      for (int i = 0; i < 50 && !found; i++) begin
         cyc(1, 0, 0, 0, m_dir, 1'b0, e);
         found = e.dw;
      end
      check_int("dw_seen_before_reset", int'(found), 1);
      @(posedge clk);
      #2;
      frame_tick = 0; start = 0; stop = 0; load_req = 0; at_top = 0; at_bot = 0;
      reset = 1'b0;
      #1;
      check_vec("async_reset", dut_vec(), rv);
      m_mode = 0; m_frames = 0; m_dir = 1'b1; m_bounce = 0;
      @(negedge clk);
      reset = 1'b1;

      // Traffic after reset
      for (int i = 0; i < 300; i++)
         c($urandom_range(0,2) == 0, $urandom_range(0,9) == 0, $urandom_range(0,29) == 0,
           $urandom_range(0,49) == 0, $urandom_range(0,4) == 0, $urandom_range(0,4) == 0);

      repeat (3) @(posedge clk);
      #5;
      check_int("scoreboard_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vline_move_ctrl.md
Name: vline_move_ctrl

Overview:
- Drives the UP/DW/LD strobes of the vertical-line position counter, acting as the initiator side of that counter's interface.
- Paces one step every STEP_FRAMES VGA frames.
- Reverses direction when the counter reports its top limit (Y=487, 0x01E7) or bottom limit (Y=18, 0x0012).
- Issues a one-cycle load of the switch value on request and keeps a saturating count of bounces for the game/score logic.

Parameters:
- STEP_FRAMES, 2, frames between successive steps (1..15)
- DIV_W, 4, width of frame divider counter
- BOUNCE_W, 8, width of bounce counter

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain)
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame (end of vertical active)
- start  in  1  level or pulse; begins motion from IDLE
- stop  in  1  pulse; returns to IDLE
- load_req  in  1  pulse; request load of switch value into position counter
- at_top  in  1  position counter upper terminal flag (Y==487)
- at_bot  in  1  position counter lower terminal flag (Y==18)
- UP  out  1  one-cycle increment strobe to position counter
- DW  out  1  one-cycle decrement strobe to position counter
- LD  out  1  one-cycle load strobe to position counter
- dir  out  1  current direction, 1=incrementing, 0=decrementing
- running  out  1  high in RUN
- bounces  out  BOUNCE_W  saturating count of direction reversals

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; UP=DW=LD=0; dir=1; running=0; bounces=0; divider=0. Deassertion is taken on the next clk edge.
- All outputs are registered. UP, DW and LD are mutually exclusive, and each is high for exactly one clk cycle per event.
- States: IDLE, LOAD, RUN.
- IDLE:
  - load_req -> LOAD.
  - else start -> RUN, with divider=0.
  - frame_tick is ignored.
- LOAD (exactly one cycle):
  - LD=1; dir<=1; divider<=0.
  - Next state is IDLE.
  - All other inputs in this cycle are ignored.
- RUN (running=1), per cycle, in priority order:
  1. load_req -> LOAD. Motion stops; the pending step is dropped.
  2. stop -> IDLE. Divider cleared; dir and bounces retained.
  3. frame_tick with divider==STEP_FRAMES-1 -> step event; divider<=0.
  4. frame_tick otherwise -> divider+1.
- Step event:
  - at_top and at_bot both high (illegal): no strobe, dir unchanged.
  - dir=1 and at_top: dir<=0, DW=1, bounces+1.
  - dir=0 and at_bot: dir<=1, UP=1, bounces+1.
  - otherwise: UP=dir, DW=~dir.
- Latency: strobe asserted in the cycle after the clock edge that samples the qualifying frame_tick.
- Limit flags are sampled only at step events. A counter loaded beyond a limit (e.g. Y=500) keeps moving in dir until a flag matches, with no extra protection.
- bounces saturates at 2^BOUNCE_W-1 and is never wrapped. It is cleared only by reset.
- start and stop high together in RUN: stop wins.
- start held high in IDLE re-enters RUN after each stop. This is intended.

Decomposition:
- Shared package vline_pkg holds:
  - state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2)
  - limit constants Y_TOP=16'd487 and Y_BOT=16'd18, so the mover and this block agree
- One natural sub-module: frame_divider (tick counter with clear, terminal-count output), reused by the horizontal line controller.

Test Plan:
- Reset mid-RUN: drive reset=0 asynchronously while DW is high -> UP/DW/LD/running/bounces go to 0 and dir to 1 immediately, without waiting for clk.
- STEP_FRAMES=2, start, 6 frame_ticks, at_top=at_bot=0 -> exactly 3 UP pulses, one per 2nd tick, each 1 cycle, 1 cycle after the tick; DW=LD=0 throughout.
- Bounce: RUN, dir=1, at_top=1 at step tick -> DW pulse, dir=0, bounces=1. Next steps give DW until at_bot=1 -> UP pulse, dir=1, bounces=2.
- load_req asserted in RUN coincident with a stepping frame_tick -> LD=1 for one cycle, no UP/DW, dir=1, state IDLE; later frame_ticks produce no strobes.
- start and stop high together in RUN -> IDLE, running=0. Force bounces to 255 via repeated limits -> stays 255.
- Illegal at_top=at_bot=1 at a step tick -> no UP/DW, dir unchanged, bounces unchanged.
